fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the controller.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch queue and presents the head word to the controller.
- Redirects on a taken jump: flushes the queue and discards any in-flight response.

---
 rtl/fetch_unit.sv | 192 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage: owns the PC, reads instruction memory
//             over req/ack and feeds a small prefetch FIFO to the controller.
//             Define FETCH_STATS_EN to add the stall/flush counter outputs.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                PC_STEP  = 4,
    parameter int                QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              dne,
    input  logic              jumping,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       flush_count
`endif
);

    localparam int                c_PTR_W = $clog2(QDEPTH);
    localparam int                c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(QDEPTH);
    localparam logic [ADDR_W-1:0] c_STEP  = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_req;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_pc;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [31:0]         r_q_data [QDEPTH];
    logic [ADDR_W-1:0]   r_q_pc   [QDEPTH];
    logic [31:0]         r_instr;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_instr_pc;

    logic                w_ack;
    logic                w_pop;
    logic                w_push;
    logic [c_CNT_W-1:0]  w_cnt_after_pop;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic                w_free;
    logic [c_PTR_W-1:0]  w_head_ptr;
    logic [31:0]         w_head_data;
    logic [ADDR_W-1:0]   w_head_pc;

    // An ack only means something while our request is actually asserted.
    assign w_ack           = imem_ack && r_req;
    assign w_pop           = dne && r_valid && !jumping;
    assign w_push          = w_ack && (r_state == ST_WAIT) && !jumping;
    assign w_cnt_after_pop = r_count - c_CNT_W'(w_pop);
    assign w_cnt_next      = jumping ? '0 : (w_cnt_after_pop + c_CNT_W'(w_push));
    assign w_free          = (w_cnt_after_pop < c_DEPTH);
    assign w_head_ptr      = r_rd_ptr + c_PTR_W'(w_pop);

    // When the queue drains to nothing this cycle, the new head is the word
    // arriving from memory rather than anything already stored.
    assign w_head_data = (w_cnt_after_pop == '0) ? imem_rdata : r_q_data[w_head_ptr];
    assign w_head_pc   = (w_cnt_after_pop == '0) ? r_pc       : r_q_pc[w_head_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]   <= r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_REQ;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_pc       <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_instr_pc <= '0;
        end else begin
            r_count <= w_cnt_next;
            r_valid <= (w_cnt_next != '0);
            if (jumping) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_cnt_next != '0) begin
                    r_instr    <= w_head_data;
                    r_instr_pc <= w_head_pc;
                end
            end

            case (r_state)
                ST_REQ: begin
                    if (jumping) begin
                        r_pc <= jump_target;
                    end else if (w_free) begin
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (jumping) begin
                        r_pc <= jump_target;
                        if (w_ack) begin
                            r_req   <= 1'b0;
                            r_state <= ST_REQ;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end else if (w_ack) begin
                        r_req   <= 1'b0;
                        r_pc    <= r_pc + c_STEP;
                        r_state <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    // Bus must see the stale request through; its data is thrown away.
                    if (jumping) begin
                        r_pc <= jump_target;
                    end
                    if (w_ack) begin
                        r_req   <= 1'b0;
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_REQ;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instruction = r_instr;
    assign instr_valid = r_valid;
    assign instr_pc    = r_instr_pc;

`ifdef FETCH_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (dne && !r_valid && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (jumping && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit with a behavioural memory
//             and a transaction-level model of the expected fetch stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          QDEPTH   = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dne;
    logic        jumping;
    logic [31:0] jump_target;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] instr_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC),
        .PC_STEP  (4),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dne         (dne),
        .jumping     (jumping),
        .jump_target (jump_target),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc)
`ifdef FETCH_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks;
    int          n_pass;
    // memory model
    logic [31:0] data_key;
    int          m_lat;
    bit          m_rand;
    bit          m_busy;
    int          m_cnt;
    logic [31:0] m_addr;
    // reference model of the fetch stream
    logic [31:0] exp_pc;
    logic [31:0] nra;
    int          occ;
    bit          stale;
    int          acks_seen;
    logic [31:0] popped[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ data_key;
    endfunction

    task automatic mem_step();
        if (imem_ack) begin
            imem_ack = 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = word(m_addr);
                m_busy     = 1'b0;
            end else begin
                m_cnt--;
            end
        end else if (imem_req) begin
            m_addr = imem_addr;
            m_busy = 1'b1;
            m_cnt  = m_rand ? int'($urandom_range(0, 3)) : (m_lat - 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        mem_step();
    endtask

    // One clock with the reference model applied to the inputs set by the caller.
    task automatic next();
        bit          pop;
        bit          acc;
        bit          p_req;
        bit          p_ack;
        logic [31:0] p_addr;
        pop = dne && instr_valid && !jumping;
        if (pop) begin
            n_checks++;
            if (instr_pc !== exp_pc || instruction !== word(exp_pc))
                $display("FAIL pop_order: got pc=%h data=%h, expected pc=%h data=%h",
                         instr_pc, instruction, exp_pc, word(exp_pc));
            else
                n_pass++;
            popped.push_back(instr_pc);
            exp_pc = exp_pc + PC_STEP;
        end
        acc = imem_req && imem_ack;
        if (acc) acks_seen++;
        if (jumping) begin
            exp_pc = jump_target;
            nra    = jump_target;
            occ    = 0;
            stale  = imem_req && !imem_ack;
        end else begin
            if (acc) begin
                if (stale) stale = 1'b0;
                else begin
                    occ++;
                    nra = nra + PC_STEP;
                end
            end
            if (pop) occ--;
        end
        p_req  = imem_req;
        p_ack  = imem_ack;
        p_addr = imem_addr;
        tick();
        n_checks++;
        if (instr_valid !== (occ != 0))
            $display("FAIL valid_occupancy: got instr_valid=%b, expected %b (occupancy %0d)",
                     instr_valid, (occ != 0), occ);
        else
            n_pass++;
        if (imem_req && !p_req) begin
            n_checks++;
            if (imem_addr !== nra || occ >= QDEPTH)
                $display("FAIL req_issue: got addr=%h occupancy=%0d, expected addr=%h occupancy<%0d",
                         imem_addr, occ, nra, QDEPTH);
            else
                n_pass++;
        end else if (imem_req && p_req && !p_ack) begin
            n_checks++;
            if (imem_addr !== p_addr)
                $display("FAIL req_hold: got addr=%h, expected %h", imem_addr, p_addr);
            else
                n_pass++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; dne = 1'b0; jumping = 1'b0; jump_target = '0;
        imem_ack = 1'b0; imem_rdata = '0; m_busy = 1'b0; m_rand = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        exp_pc = RESET_PC; nra = RESET_PC; occ = 0; stale = 1'b0; acks_seen = 0;
        popped.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL reset_req: got %b, expected 0", imem_req); else n_pass++;
        n_checks++;
        if (imem_addr !== RESET_PC) $display("FAIL reset_addr: got %h, expected %h", imem_addr, RESET_PC); else n_pass++;
        n_checks++;
        if (instruction !== 32'h0) $display("FAIL reset_instr: got %h, expected 0", instruction); else n_pass++;
        n_checks++;
        if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", instr_valid); else n_pass++;
        n_checks++;
        if (instr_pc !== 32'h0) $display("FAIL reset_pc: got %h, expected 0", instr_pc); else n_pass++;
    endtask

    task automatic test_stream();
        int k;
        apply_reset();
        m_lat = 1; data_key = '0; dne = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next();
            n_checks++;
            if (instr_valid !== 1'b0) $display("FAIL first_latency_early: cycle %0d instr_valid=%b, expected 0", i + 1, instr_valid);
            else n_pass++;
        end
        next();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instruction !== 32'h0)
            $display("FAIL first_latency: cycle 3 got valid=%b pc=%h instr=%h, expected 1/0/0", instr_valid, instr_pc, instruction);
        else n_pass++;
        k = 0;
        while (popped.size() < 4 && k < 60) begin next(); k++; end
        n_checks++;
        if (popped.size() < 4 || popped[0] !== 32'h0 || popped[1] !== 32'h4 || popped[2] !== 32'h8 || popped[3] !== 32'hC)
            $display("FAIL stream_order: got %0d words starting %h %h %h %h, expected 0 4 8 c",
                     popped.size(), popped[0], popped[1], popped[2], popped[3]);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        apply_reset();
        m_lat = 1; data_key = '0; dne = 1'b0;
        repeat (10) next();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instruction !== 32'h0)
            $display("FAIL bp_head: got valid=%b pc=%h instr=%h, expected 1/0/0", instr_valid, instr_pc, instruction);
        else n_pass++;
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL bp_full_req: got imem_req=%b, expected 0", imem_req); else n_pass++;
        n_checks++;
        if (acks_seen !== QDEPTH) $display("FAIL bp_words: got %0d acks, expected %0d", acks_seen, QDEPTH); else n_pass++;
        dne = 1'b1;
        next();
        next();
        dne = 1'b0;
        n_checks++;
        if (popped.size() != 2 || popped[0] !== 32'h0 || popped[1] !== 32'h4)
            $display("FAIL bp_drain: got %0d pops %h %h, expected 2 pops 0 4", popped.size(), popped[0], popped[1]);
        else n_pass++;
    endtask

    task automatic test_late_jump();
        int          k;
        bit          pr;
        bit          got;
        logic [31:0] first_addr;
        apply_reset();
        m_lat = 4; data_key = '0; dne = 1'b1;
        next();
        next();
        jumping = 1'b1; jump_target = 32'h100;
        next();
        jumping = 1'b0;
        k = 0; got = 1'b0; first_addr = '0;
        while (!instr_valid && k < 40) begin
            pr = imem_req;
            next();
            if (imem_req && !pr && !got) begin got = 1'b1; first_addr = imem_addr; end
            k++;
        end
        n_checks++;
        if (!got || first_addr !== 32'h100) $display("FAIL late_jump_addr: got %h (issued=%b), expected 100", first_addr, got);
        else n_pass++;
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instruction !== 32'h100)
            $display("FAIL late_jump_first: got valid=%b pc=%h instr=%h, expected 1/100/100", instr_valid, instr_pc, instruction);
        else n_pass++;
        dne = 1'b0;
    endtask

    task automatic test_jump_ack_pop();
        int k;
        apply_reset();
        m_lat = 1; data_key = '0; dne = 1'b0;
        k = 0;
        while (!(imem_ack && instr_valid) && k < 40) begin next(); k++; end
        n_checks++;
        if (!(imem_ack && instr_valid)) $display("FAIL jap_setup: got ack=%b valid=%b, expected both 1", imem_ack, instr_valid);
        else n_pass++;
        dne = 1'b1; jumping = 1'b1; jump_target = 32'h40;
        next();
        jumping = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0) $display("FAIL jap_flush: got instr_valid=%b, expected 0", instr_valid); else n_pass++;
        k = 0;
        while (!instr_valid && k < 40) begin next(); k++; end
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instruction !== 32'h40)
            $display("FAIL jap_target: got valid=%b pc=%h instr=%h, expected 1/40/40", instr_valid, instr_pc, instruction);
        else n_pass++;
        dne = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        int k;
        apply_reset();
        m_lat = 1; data_key = '0; dne = 1'b1;
        k = 0;
        while (!(imem_req && imem_addr == 32'h4) && k < 40) begin next(); k++; end
        n_checks++;
        if (!(imem_req && imem_addr == 32'h4)) $display("FAIL riw_setup: got req=%b addr=%h, expected 1/4", imem_req, imem_addr);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL riw_abort: got req=%b valid=%b, expected 0/0", imem_req, instr_valid);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0)
            $display("FAIL riw_restart: got req=%b addr=%h valid=%b, expected 1/%h/0", imem_req, imem_addr, instr_valid, RESET_PC);
        else n_pass++;
        k = 0;
        while (!instr_valid && k < 40) begin tick(); k++; end
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instruction !== word(RESET_PC))
            $display("FAIL riw_first: got valid=%b pc=%h instr=%h, expected 1/%h/%h",
                     instr_valid, instr_pc, instruction, RESET_PC, word(RESET_PC));
        else n_pass++;
        dne = 1'b0;
    endtask

    task automatic test_pc_wrap();
        apply_reset();
        m_lat = 1; data_key = '0; dne = 1'b0;
        jumping = 1'b1; jump_target = 32'hFFFF_FFFC;
        next();
        jumping = 1'b0;
        repeat (12) next();
        dne = 1'b1;
        next();
        next();
        dne = 1'b0;
        n_checks++;
        if (popped.size() != 2 || popped[0] !== 32'hFFFF_FFFC || popped[1] !== 32'h0)
            $display("FAIL pc_wrap: got %0d pops %h %h, expected fffffffc 00000000", popped.size(), popped[0], popped[1]);
        else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        m_rand = 1'b1;
        data_key = 32'h5A5A_0000 ^ $urandom;
        for (int i = 0; i < 3000; i++) begin
            dne         = ($urandom_range(0, 9) < 7);
            jumping     = ($urandom_range(0, 19) == 0);
            jump_target = $urandom & 32'hFFFF_FFFC;
            next();
        end
        jumping = 1'b0; dne = 1'b0;
        n_checks++;
        if (popped.size() < 100) $display("FAIL random_progress: got %0d words, expected at least 100", popped.size());
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        reset = 1'b1; dne = 1'b0; jumping = 1'b0; jump_target = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        m_busy = 1'b0; m_cnt = 0; m_addr = '0; m_lat = 1; m_rand = 1'b0; data_key = '0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_late_jump();
        test_jump_ack_pop();
        test_reset_in_wait();
        test_pc_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
